// File: rtl/hex_seq_ctrl_pkg.sv
// hex_seq_pkg: state encodings, segment patterns and direction constants for the HEX0 ring
package hex_seq_pkg;
  localparam int STATE_W = 5;
  localparam logic DIR_F = 1'b1;
  localparam logic DIR_B = 1'b0;
  typedef enum logic [STATE_W-1:0] {
    S_A = 5'b00001,
    S_B = 5'b00010,
    S_C = 5'b00100,
    S_D = 5'b01000,
    S_E = 5'b10000
  } state_t;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  function automatic logic [6:0] seg_of(state_t s);
    return s == S_B ? SEG_0 : s == S_C ? SEG_4 : s == S_D ? SEG_8 : s == S_E ? SEG_3 : SEG_6;
  endfunction
endpackage

// File: rtl/hex_seq_ctrl_if.sv
// hex_seq_ctrl_if: board controls in, digit state and segment/status outputs back
interface hex_seq_ctrl_if;
  import hex_seq_pkg::*;
  logic step_n;
  logic auto_en;
  logic hold;
  logic dir;
  logic [STATE_W-1:0] state;
  logic [6:0] hex;
  logic step_pulse;
  logic wrap;
  modport master(output step_n, auto_en, hold, dir, input state, hex, step_pulse, wrap);
  modport slave(input step_n, auto_en, hold, dir, output state, hex, step_pulse, wrap);
endinterface

// File: rtl/hex_seq_ctrl_step_sync.sv
// step_sync: two-flop synchronizer plus edge flop, one-cycle req on a falling step key
module step_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic step_n,
  output logic req
);
  logic s1, s2, s3;
  always_ff @(posedge clk)
    if (!reset_n) {s1, s2, s3} <= 3'b111;
    else {s1, s2, s3} <= {step_n, s1, s2};
  assign req = s3 & ~s2;
endmodule

// File: rtl/hex_seq_ctrl.sv
// hex_seq_ctrl: auto/manual step merge driving the one-hot HEX0 digit ring and its outputs
module hex_seq_ctrl
  import hex_seq_pkg::*;
#(
  parameter int TICK_W   = 26,
  parameter int TICK_DIV = 50000000
) (
  input logic clk,
  input logic reset_n,
  hex_seq_ctrl_if.slave bus
);
  state_t state_q, nxt;
  logic [6:0] hex_q;
  logic pulse_q, wrap_q;
  logic [TICK_W-1:0] cnt;
  logic req, run, tick, adv, legal, wrap_c;
  step_sync u_sync (.clk(clk), .reset_n(reset_n), .step_n(bus.step_n), .req(req));
  assign run    = bus.auto_en & ~bus.hold;
  assign tick   = run && cnt == TICK_W'(TICK_DIV - 1);
  assign legal  = state_q != '0 && (state_q & (state_q - 1'b1)) == '0;
  // an advance right after another is dropped so the status pulses never run together
  assign adv    = (tick | req) & ~pulse_q;
  assign nxt    = bus.dir == DIR_F ? state_t'({state_q[3:0], state_q[4]}) : state_t'({state_q[0], state_q[4:1]});
  assign wrap_c = bus.dir == DIR_F ? state_q[4] : state_q[0];
  always_ff @(posedge clk)
    if (!reset_n || !bus.auto_en) cnt <= '0;
    else if (!bus.hold) cnt <= tick ? '0 : cnt + 1'b1;
  always_ff @(posedge clk)
    if (!reset_n || !legal) begin
      state_q <= S_A;
      hex_q   <= SEG_6;
      pulse_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      pulse_q <= adv;
      wrap_q  <= adv & wrap_c;
      if (adv) begin
        state_q <= nxt;
        hex_q   <= seg_of(nxt);
      end
    end
  assign bus.state      = state_q;
  assign bus.hex        = hex_q;
  assign bus.step_pulse = pulse_q;
  assign bus.wrap       = wrap_q;
endmodule

// File: tb/tb_hex_seq_ctrl.sv
// tb_hex_seq_ctrl: directed scenario tests of hex_seq_ctrl with TICK_DIV=4
module tb_hex_seq_ctrl;
  import hex_seq_pkg::*;
  logic clk = 1'b0;
  logic reset_n;
  int total = 0;
  int passed = 0;
  logic [4:0] st_tab [5] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
  logic [6:0] sg_tab [5] = '{7'b0000010, 7'b1000000, 7'b0011001, 7'b0000000, 7'b0110000};
  hex_seq_ctrl_if bus ();
  hex_seq_ctrl #(.TICK_W(26), .TICK_DIV(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string nm, input int idx, input logic p, input logic w);
    total++; if (bus.state !== st_tab[idx]) $display("FAIL %s state got %b want %b", nm, bus.state, st_tab[idx]); else passed++;
    total++; if (bus.hex !== sg_tab[idx]) $display("FAIL %s hex got %b want %b", nm, bus.hex, sg_tab[idx]); else passed++;
    total++; if (bus.step_pulse !== p) $display("FAIL %s step_pulse got %b want %b", nm, bus.step_pulse, p); else passed++;
    total++; if (bus.wrap !== w) $display("FAIL %s wrap got %b want %b", nm, bus.wrap, w); else passed++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; bus.step_n = 1'b0; bus.auto_en = 1'b1; bus.hold = 1'b0; bus.dir = 1'b1;
    cyc(); cyc();
    bus.step_n = 1'b1;
    cyc();
    chk_out("reset", 0, 1'b0, 1'b0);
  endtask

  task automatic test_auto_forward();
    reset_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      cyc();
      chk_out($sformatf("auto_e%0d", e), (e / 4) % 5, e % 4 == 0, e == 20);
    end
  endtask

  task automatic test_manual_hold();
    bus.auto_en = 1'b0; bus.dir = 1'b0; bus.step_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk_out($sformatf("man_e%0d", k), k >= 3 ? 4 : 0, k == 3, k == 3);
    end
    bus.step_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk_out($sformatf("release_%0d", k), 4, 1'b0, 1'b0);
    end
    bus.step_n = 1'b0;
    cyc(); cyc();
    chk_out("repress_e2", 4, 1'b0, 1'b0);
    cyc();
    chk_out("repress_e3", 3, 1'b1, 1'b0);
    bus.step_n = 1'b1;
    cyc(); cyc(); cyc();
    chk_out("repress_idle", 3, 1'b0, 1'b0);
  endtask

  task automatic test_merge();
    bus.dir = 1'b1; bus.auto_en = 1'b1;
    cyc();
    bus.step_n = 1'b0;
    cyc(); cyc();
    chk_out("merge_e3", 3, 1'b0, 1'b0);
    cyc();
    chk_out("merge_e4", 4, 1'b1, 1'b0);
    cyc();
    chk_out("merge_e5", 4, 1'b0, 1'b0);
    bus.step_n = 1'b1;
  endtask

  task automatic test_hold();
    cyc();
    bus.hold = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk_out($sformatf("hold_%0d", k), 4, 1'b0, 1'b0);
    end
    bus.hold = 1'b0;
    cyc();
    chk_out("unhold_1", 4, 1'b0, 1'b0);
    cyc();
    chk_out("unhold_2", 0, 1'b1, 1'b1);
  endtask

  task automatic test_illegal();
    bus.auto_en = 1'b0;
    cyc(); cyc();
    force dut.state_q = state_t'(5'b00110);
    #1 release dut.state_q;
    total++; if (bus.state !== 5'b00110) $display("FAIL illegal_setup state got %b want %b", bus.state, 5'b00110); else passed++;
    cyc();
    chk_out("illegal", 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    bus.auto_en = 1'b1; bus.dir = 1'b1;
    for (int k = 1; k <= 14; k++) cyc();
    chk_out("pre_reset", 3, 1'b0, 1'b0);
    reset_n = 1'b0;
    cyc();
    chk_out("mid_reset", 0, 1'b0, 1'b0);
    reset_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk_out($sformatf("post_reset_%0d", k), k == 4 ? 1 : 0, k == 4, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_auto_forward();
    test_manual_hold();
    test_merge();
    test_hold();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hex_seq_ctrl.md
Name: hex_seq_ctrl

Overview:
- Sequencing controller for the five-digit HEX0 display ring (6, 0, 4, 8, 3).
- Generates step events from two sources: a free-running divider (auto mode) and a debounced-by-edge manual step key.
- Applies direction and hold controls, and advances the one-hot digit state.
- Drives the registered 7-segment pattern plus status pulses; sits between the board KEY/SW inputs and HEX0.

Parameters:
- TICK_W, 26, width of the auto-step divider counter.
- TICK_DIV, 50000000, clk cycles per auto step (legal range 2..2^TICK_W-1).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- step_n  input  1  raw active-low manual step key, asynchronous to clk.
- auto_en  input  1  1 = divider-driven stepping enabled.
- hold  input  1  1 = freeze auto stepping; manual steps still honoured.
- dir  input  1  1 = forward (Sa->Sb->Sc->Sd->Se->Sa), 0 = backward.
- state  output  5  one-hot present digit state.
- hex  output  7  active-low segment pattern for the present state.
- step_pulse  output  1  one-cycle pulse, high in the cycle after a state advance.
- wrap  output  1  one-cycle pulse when the advance crossed the Se/Sa boundary.

Behaviour:
- Reset (reset_n low at a rising edge):
  - state=Sa (5'b00001), hex=7'b0000010.
  - Divider count=0; sync flops=1; step_pulse=0; wrap=0.
  - Reset dominates all other inputs.
- State encodings: Sa=00001, Sb=00010, Sc=00100, Sd=01000, Se=10000.
- Segment patterns: Sa->0000010 (6), Sb->1000000 (0), Sc->0011001 (4), Sd->0000000 (8), Se->0110000 (3).
- hex is registered and updates on the same edge as state; it is never a stale pattern.
- Manual path:
  - step_n passes through 2 sync flops plus 1 edge flop.
  - A falling edge on the synchronized signal produces one internal step request.
  - If step_n is first sampled low at edge E1, state advances at E3.
  - Holding step_n low produces exactly one step; release produces none.
- Auto path:
  - Divider increments each cycle while auto_en=1 and hold=0.
  - At count TICK_DIV-1 it returns to 0 and issues a tick.
  - When auto_en=0, the divider clears to 0 on the next edge.
  - When hold=1, the divider keeps its value (paused, not cleared).
  - With auto_en=1 from reset release, the first advance happens at edge TICK_DIV.
- Step merge:
  - A tick and a manual request in the same cycle cause exactly one advance.
- Advance:
  - The next state follows dir as sampled in the advance cycle.
  - A dir change mid-dwell only affects the next advance.
- Illegal state (not one-hot): the next edge forces Sa / 0000010 regardless of step; no pulses.
- step_pulse and wrap:
  - Both are registered, high for the one cycle after an advance, and never high two cycles in a row.
  - wrap=1 only for Se->Sa (forward) or Sa->Se (backward).
- Reset mid-dwell or mid-sync discards the pending request and divider count.

Decomposition:
- Package hex_seq_pkg:
  - State encodings S_A..S_E.
  - Segment constants SEG_6, SEG_0, SEG_4, SEG_8, SEG_3.
  - DIR_F=1, DIR_B=0, and the state width constant 5.
- Sub-module step_sync:
  - 2-flop synchronizer, edge flop and falling-edge detect.
  - Same clk/reset_n; reset value 1 on all flops.
  - Output is a one-cycle req pulse.
- The divider, merge, next-state logic and output registers stay in hex_seq_ctrl.

Test Plan (TICK_DIV=4):
- Reset, auto_en=1, hold=0, dir=1 for 20 cycles -> state Sb at edge 4, Sc at 8, Sd at 12, Se at 16, Sa at 20; hex goes 1000000, 0011001, 0000000, 0110000, 0000010; wrap=1 only in the cycle after edge 20.
- auto_en=0, dir=0, step_n low at E1 and held 10 cycles -> single advance Sa->Se at E3; hex=0110000; wrap=1 for one cycle; no further advance until release and re-press.
- auto_en=1, manual request timed to coincide with a tick -> exactly one advance; step_pulse high for one cycle only.
- hold=1 at count 2 for 6 cycles, then hold=0 -> no advance during hold; advance exactly 2 cycles after release.
- Force state to 5'b00110 via the bench -> Sa/0000010 on the next edge, with step_pulse=0 and wrap=0.
- reset_n low for one edge mid-dwell at state Sd -> Sa/0000010 and count restarts; next auto advance 4 edges after reset_n returns high.
